bar_height_scheduler: RTL and testbench
=======================================

Name: bar_height_scheduler

Overview:
- Per-frame controller between the spectrum magnitude store and the bar graph renderer.
- On each frame-start pulse it walks NUM_BARS bins over a request/valid read handshake, scales and clamps each magnitude to a pixel height, applies the switch enable mask and fall-off decay, then commits all heights atomically so the renderer never draws a half-updated frame.

Parameters:
- NUM_BARS, 10, number of bars / bins scheduled per frame
- MAG_W, 16, width of magnitude word from spectrum store
- ADDR_W, 8, width of bin address
- BIN_BASE, 0, address of first bin
- BIN_STRIDE, 1, address increment per bar
- SHIFT, 6, right shift applied to magnitude before clamp
- MAX_H, 479, maximum bar height in pixels (10-bit)
- DECAY, 8, maximum pixels a bar may fall per frame
- TIMEOUT, 15, cycles to wait for bin_valid before substituting 0

Ports:
- MAX10_CLK1_50  in  1  system clock, 50 MHz, single clock domain
- Reset_h  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- bar_en  in  NUM_BARS  per-bar enable (driven from SW)
- bin_req  out  1  read request to spectrum store
- bin_addr  out  ADDR_W  bin address, stable while bin_req high
- bin_valid  in  1  read data valid
- bin_data  in  MAG_W  magnitude
- bar_height  out  10*NUM_BARS  packed committed heights, bar i at [10*i+9:10*i]
- busy  out  1  high whenever state is not IDLE
- frame_done  out  1  one-cycle pulse coincident with the commit
- overrun  out  1  sticky; set when frame_start arrives while busy

Behaviour:
- Reset (synchronous, any state):
  - state=IDLE; bar_height, shadow, index and timeout counter = 0.
  - bin_req=0, bin_addr=BIN_BASE, frame_done=0, overrun=0.
- FSM states: IDLE, REQ, PROC, COMMIT.
- IDLE:
  - frame_start -> REQ, index=0.
  - Otherwise stay in IDLE.
- REQ:
  - bin_req=1, bin_addr=BIN_BASE+index*BIN_STRIDE (truncated to ADDR_W).
  - bin_valid sampled the same cycle: capture bin_data -> PROC.
  - Timeout counter increments each REQ cycle without valid. When it reaches TIMEOUT, captured magnitude=0 -> PROC.
  - Counter clears on leaving REQ.
- PROC (bin_req=0):
  - scaled = bin_data>>SHIFT, saturated to MAX_H.
  - If bar_en[index]=0: shadow[index]=0.
  - Else if scaled >= shadow[index]: shadow[index]=scaled.
  - Else: shadow[index] = max(scaled, shadow[index]-DECAY), with the subtraction floored at 0.
  - index==NUM_BARS-1 -> COMMIT; otherwise index++ -> REQ.
- COMMIT:
  - bar_height<=shadow (all bars in one edge); frame_done=1 for one cycle, visible with the new bar_height.
  - Then -> IDLE.
- Latency with zero-wait valid:
  - frame_start sampled at edge 0; bar_height/frame_done change at edge 2*NUM_BARS+2 (22 for defaults).
  - Each wait cycle adds one.
- frame_start while busy: ignored (walk continues uninterrupted), overrun set. Only reset clears overrun.
- frame_start in the same cycle as COMMIT: counts as busy (overrun set, no new walk).
- bin_valid outside REQ: ignored.
- bar_en sampled per bar during its PROC cycle, not latched at frame start.
- Decay uses shadow (the previous committed value, since shadow==bar_height between walks).

Optional Feature:
- Macro: BAR_PEAK_HOLD_EN.
- Defined:
  - Adds output peak_height (10*NUM_BARS) and parameter HOLD_FRAMES (default 30).
  - Per bar, in PROC: if new shadow >= peak, peak=new shadow and hold counter=HOLD_FRAMES.
  - Otherwise, if hold>0, hold--; else peak drops by DECAY, floored at shadow.
  - Peaks commit together with bar_height. Disabled bars clear peak and hold.
- Undefined: no peak port, registers or counters; behaviour otherwise identical.

Decomposition:
- Package bar_pkg holds:
  - NUM_BARS, HEIGHT_W=10, MAX_H, MAG_W
  - the state enum (IDLE, REQ, PROC, COMMIT)
  - the height_t typedef (logic [9:0])
- One sub-module, bar_height_calc: combinational scale/clamp/decay from (mag, prev, en) to the next height. It is reused for the peak path when BAR_PEAK_HOLD_EN is defined.

Test Plan:
- Reset then frame_start with bin_valid tied high, bin_data=16'h1000 for all bins, bar_en=10'h3FF -> all heights 64, frame_done at edge 22, bin_addr sequence 0..9.
- Previous heights 64, next frame bin_data=0 -> heights 56, then 48 on the following frame; bin_data=16'hFFFF -> heights 479 (saturation).
- bar_en=10'h001 with bin_data=16'h1000 -> bar0=64, bars1-9=0; clearing bar_en[0] on the next frame -> bar0=0 immediately (no decay).
- bin_valid never asserted for bar 3 -> bin_req held 15 cycles, bar3 treated as magnitude 0, walk completes, frame_done at edge 36.
- Second frame_start pulse at edge 10 of a walk -> overrun=1 and stays 1, walk unaffected, exactly one frame_done; Reset_h at edge 12 -> all outputs 0, state IDLE.
- With BAR_PEAK_HOLD_EN and HOLD_FRAMES=2: heights 64 then zero input -> peak stays 64 for 2 frames, then 56 while bar falls 56,48,40.

Source files
------------

// File: rtl/bar_height_scheduler_pkg.sv
// Shared constants, FSM state encoding and height type for the bar height scheduler.
package bar_pkg;
   localparam int NUM_BARS = 10;
   localparam int HEIGHT_W = 10;
   localparam int MAX_H    = 479;
   localparam int MAG_W    = 16;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      PROC,
      COMMIT
   } state_t;

   typedef logic [HEIGHT_W-1:0] height_t;
endpackage

// File: rtl/bar_height_scheduler_calc.sv
// Combinational scale, clamp and fall-off for one bar: next height from magnitude,
// previous height and enable. Also used with SHIFT=0 for the peak-hold path.
module bar_height_calc
   import bar_pkg::*;
#(
   parameter int SHIFT = 6,
   parameter int DECAY = 8
) (
   input  logic [MAG_W-1:0] mag,
   input  height_t          prev,
   input  logic             en,
   output height_t          height
);

   logic [MAG_W-1:0] shifted;
   height_t          scaled;
   height_t          decayed;

   always_comb begin
      shifted = mag >> SHIFT;
      if (shifted > MAG_W'(MAX_H)) scaled = height_t'(MAX_H);
      else                         scaled = shifted[HEIGHT_W-1:0];

      decayed = (prev > height_t'(DECAY)) ? prev - height_t'(DECAY) : '0;

      if (!en)                  height = '0;
      else if (scaled >= prev)  height = scaled;
      else if (scaled > decayed) height = scaled;
      else                      height = decayed;
   end

endmodule

// File: rtl/bar_height_scheduler.sv
// Per-frame bar height scheduler: walks the spectrum bins, updates shadow heights, commits atomically.
// Optional peak-hold tracking is enabled by defining BAR_PEAK_HOLD_EN.
//
//   state  | meaning
//   IDLE   | waiting for a registered frame start
//   REQ    | bin_req high, waiting for bin_valid or timeout
//   PROC   | scale/clamp/decay current bar into shadow
//   COMMIT | copy all shadow heights to outputs, pulse frame_done
module bar_height_scheduler
   import bar_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int BIN_BASE   = 0,
   parameter int BIN_STRIDE = 1,
   parameter int SHIFT      = 6,
   parameter int DECAY      = 8,
   parameter int TIMEOUT    = 15
`ifdef BAR_PEAK_HOLD_EN
  ,parameter int HOLD_FRAMES = 30
`endif
) (
   input  logic                         MAX10_CLK1_50,
   input  logic                         Reset_h,
   input  logic                         frame_start,
   input  logic [NUM_BARS-1:0]          bar_en,
   output logic                         bin_req,
   output logic [ADDR_W-1:0]            bin_addr,
   input  logic                         bin_valid,
   input  logic [MAG_W-1:0]             bin_data,
   output logic [HEIGHT_W*NUM_BARS-1:0] bar_height,
   output logic                         busy,
   output logic                         frame_done,
   output logic                         overrun
`ifdef BAR_PEAK_HOLD_EN
  ,output logic [HEIGHT_W*NUM_BARS-1:0] peak_height
`endif
);

   localparam int IDX_W = $clog2(NUM_BARS);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] index;
   logic [TMO_W-1:0] tmo;
   logic [MAG_W-1:0] mag;
   logic             start_q;
   height_t          shadow [NUM_BARS];
   height_t          height_nxt;
   logic             last_bar;
   logic             tmo_hit;

   assign busy     = (state != IDLE);
   assign last_bar = (index == IDX_W'(NUM_BARS - 1));
   assign tmo_hit  = (tmo == TMO_W'(TIMEOUT - 1));
   assign bin_addr = ADDR_W'(BIN_BASE + int'(index) * BIN_STRIDE);

   bar_height_calc #(.SHIFT(SHIFT), .DECAY(DECAY)) u_calc (
      .mag    (mag),
      .prev   (shadow[index]),
      .en     (bar_en[index]),
      .height (height_nxt)
   );

   always_comb begin
      state_nxt = state;
      bin_req   = 1'b0;
      case (state)
         IDLE:    if (start_q) state_nxt = REQ;
         REQ: begin
            bin_req = 1'b1;
            if (bin_valid || tmo_hit) state_nxt = PROC;
         end
         PROC:    state_nxt = last_bar ? COMMIT : REQ;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef BAR_PEAK_HOLD_EN
   localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
   height_t           peak   [NUM_BARS];
   logic [HOLD_W-1:0] hold   [NUM_BARS];
   height_t           peak_drop;

   // Same fall-off rule applied to the peak, floored at the new bar height.
   bar_height_calc #(.SHIFT(0), .DECAY(DECAY)) u_peak_calc (
      .mag    (MAG_W'(height_nxt)),
      .prev   (peak[index]),
      .en     (1'b1),
      .height (peak_drop)
   );

   always_ff @(posedge MAX10_CLK1_50) begin
      if (Reset_h) begin
         peak_height <= '0;
         for (int i = 0; i < NUM_BARS; i++) begin
            peak[i] <= '0;
            hold[i] <= '0;
         end
      end else if (state == PROC) begin
         if (!bar_en[index]) begin
            peak[index] <= '0;
            hold[index] <= '0;
         end else if (height_nxt >= peak[index]) begin
            peak[index] <= height_nxt;
            hold[index] <= HOLD_W'(HOLD_FRAMES);
         end else if (hold[index] != '0) begin
            hold[index] <= hold[index] - 1'b1;
         end else begin
            peak[index] <= peak_drop;
         end
      end else if (state == COMMIT) begin
         for (int i = 0; i < NUM_BARS; i++) peak_height[i*HEIGHT_W +: HEIGHT_W] <= peak[i];
      end
   end
`endif

   // frame_start is registered once before the FSM sees it; a pulse landing while a
   // walk is pending or running only flags overrun.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (Reset_h) begin
         state      <= IDLE;
         index      <= '0;
         tmo        <= '0;
         mag        <= '0;
         start_q    <= 1'b0;
         overrun    <= 1'b0;
         frame_done <= 1'b0;
         bar_height <= '0;
         for (int i = 0; i < NUM_BARS; i++) shadow[i] <= '0;
      end else begin
         state      <= state_nxt;
         frame_done <= 1'b0;
         start_q    <= frame_start && !busy && !start_q;
         if (frame_start && (busy || start_q)) overrun <= 1'b1;
         case (state)
            IDLE: if (start_q) index <= '0;
            REQ: begin
               if (bin_valid) begin
                  mag <= bin_data;
                  tmo <= '0;
               end else if (tmo_hit) begin
                  mag <= '0;
                  tmo <= '0;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            PROC: begin
               shadow[index] <= height_nxt;
               if (!last_bar) index <= index + 1'b1;
            end
            COMMIT: begin
               frame_done <= 1'b1;
               index      <= '0;
               for (int i = 0; i < NUM_BARS; i++) bar_height[i*HEIGHT_W +: HEIGHT_W] <= shadow[i];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bar_height_scheduler.sv
// Directed bench for bar_height_scheduler: table of frames plus timeout, overrun and reset sequences.
module tb_bar_height_scheduler;
   import bar_pkg::*;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frame_start = 1'b0;
   logic [9:0]    bar_en = 10'h3FF;
   logic          bin_req;
   logic [7:0]    bin_addr;
   logic          bin_valid;
   logic [15:0]   bin_data = 16'h0;
   logic [99:0]   bar_height;
   logic          busy;
   logic          frame_done;
   logic          overrun;
   logic          drop_en = 1'b0;
`ifdef BAR_PEAK_HOLD_EN
   logic [99:0]   peak_height;
`endif

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   // Bin 3 can be made to never answer; otherwise the store answers immediately.
   assign bin_valid = !(drop_en && bin_addr == 8'd3);

   bar_height_scheduler dut (
      .MAX10_CLK1_50 (clk),
      .Reset_h       (rst),
      .frame_start   (frame_start),
      .bar_en        (bar_en),
      .bin_req       (bin_req),
      .bin_addr      (bin_addr),
      .bin_valid     (bin_valid),
      .bin_data      (bin_data),
      .bar_height    (bar_height),
      .busy          (busy),
      .frame_done    (frame_done),
      .overrun       (overrun)
`ifdef BAR_PEAK_HOLD_EN
     ,.peak_height   (peak_height)
`endif
   );

   typedef struct {
      logic [15:0] mag;
      logic [9:0]  en;
      logic [9:0]  exp_h;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string nm, input logic [99:0] act, input logic [99:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [99:0] pack(input logic [9:0] h, input logic [9:0] en);
      logic [99:0] r;
      r = '0;
      for (int i = 0; i < 10; i++) if (en[i]) r[i*10 +: 10] = h;
      return r;
   endfunction

   // Pulses frame_start (sampled at edge 0) and watches a fixed window of edges.
   task automatic run_frame(input int extra_start, input int rst_edge, input int window,
                            output int done_edge, output int done_cnt,
                            output int addr_errs, output int req_cnt, output int max_run);
      int n, run;
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      n = 0; run = 0; done_edge = -1; done_cnt = 0; addr_errs = 0; req_cnt = 0; max_run = 0;
      while (n < window) begin
         if (n + 1 == extra_start) frame_start = 1'b1;
         if (n + 1 == rst_edge) rst = 1'b1;
         @(posedge clk); #1;
         n++;
         frame_start = 1'b0;
         rst = 1'b0;
         if (frame_done) begin
            done_cnt++;
            if (done_edge < 0) done_edge = n;
         end
         if (bin_req) begin
            if (run == 0) begin
               if (bin_addr != 8'(req_cnt)) addr_errs++;
               req_cnt++;
            end
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
      end
   endtask

   initial begin
      int de, dc, ae, rc, mr;
      vecs[0]  = '{16'h1000, 10'h3FF, 10'd64};
      vecs[1]  = '{16'h0000, 10'h3FF, 10'd56};
      vecs[2]  = '{16'h0000, 10'h3FF, 10'd48};
      vecs[3]  = '{16'h0C40, 10'h3FF, 10'd49};
      vecs[4]  = '{16'h0A00, 10'h3FF, 10'd41};
      vecs[5]  = '{16'h0100, 10'h3FF, 10'd33};
      vecs[6]  = '{16'hFFFF, 10'h3FF, 10'd479};
      vecs[7]  = '{16'h7800, 10'h3FF, 10'd479};
      vecs[8]  = '{16'h0000, 10'h3FF, 10'd471};
      vecs[9]  = '{16'h1000, 10'h001, 10'd463};
      vecs[10] = '{16'h1000, 10'h000, 10'd0};
      vecs[11] = '{16'h0180, 10'h3FF, 10'd6};
      vecs[12] = '{16'h0000, 10'h3FF, 10'd0};

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_height", bar_height, '0);
      check("reset_busy", {99'b0, busy}, '0);
      check("reset_req", {99'b0, bin_req}, '0);
      check("reset_addr", {92'b0, bin_addr}, '0);
      check("reset_done_ovr", {98'b0, frame_done, overrun}, '0);

      foreach (vecs[k]) begin
         bin_data = vecs[k].mag;
         bar_en   = vecs[k].en;
         run_frame(-1, -1, 30, de, dc, ae, rc, mr);
         check($sformatf("v%0d_height", k), bar_height, pack(vecs[k].exp_h, vecs[k].en));
         check($sformatf("v%0d_done_edge", k), 100'(de), 100'(22));
         check($sformatf("v%0d_done_cnt", k), 100'(dc), 100'(1));
         check($sformatf("v%0d_addr_seq", k), 100'(ae + 100 * (rc - 10)), '0);
      end
      check("idle_busy", {99'b0, busy}, '0);
      check("no_overrun_yet", {99'b0, overrun}, '0);

      // Bin 3 never answers: 15 request cycles, bar 3 treated as zero magnitude.
      drop_en  = 1'b1;
      bin_data = 16'h1000;
      bar_en   = 10'h3FF;
      run_frame(-1, -1, 45, de, dc, ae, rc, mr);
      drop_en  = 1'b0;
      check("tmo_done_edge", 100'(de), 100'(36));
      check("tmo_req_run", 100'(mr), 100'(15));
      check("tmo_height", bar_height, pack(10'd64, 10'h3F7));
      check("tmo_addr_seq", 100'(ae + 100 * (rc - 10)), '0);

      // frame_start landing on the COMMIT cycle is an overrun, no second walk.
      run_frame(22, -1, 45, de, dc, ae, rc, mr);
      check("commit_ovr", {99'b0, overrun}, 100'(1));
      check("commit_one_walk", 100'(rc), 100'(10));
      check("commit_done_cnt", 100'(dc), 100'(1));
      check("commit_idle", {99'b0, busy}, '0);

      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("rst_clears_ovr", {99'b0, overrun}, '0);
      check("rst_clears_height", bar_height, '0);

      // Second pulse mid-walk: overrun set, walk unaffected.
      bin_data = 16'h1000;
      run_frame(10, -1, 45, de, dc, ae, rc, mr);
      check("mid_ovr", {99'b0, overrun}, 100'(1));
      check("mid_done_edge", 100'(de), 100'(22));
      check("mid_done_cnt", 100'(dc), 100'(1));
      check("mid_one_walk", 100'(rc), 100'(10));
      check("mid_height", bar_height, pack(10'd64, 10'h3FF));

      // Reset at edge 12 of a walk: everything back to idle, no commit follows.
      run_frame(-1, 12, 30, de, dc, ae, rc, mr);
      check("rst12_done_cnt", 100'(dc), '0);
      check("rst12_height", bar_height, '0);
      check("rst12_flags", {96'b0, busy, bin_req, frame_done, overrun}, '0);
      check("rst12_addr", {92'b0, bin_addr}, '0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
